seq_divider: RTL

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider_if.sv | 23 ++
 rtl/seq_divider.sv | 139 +++++++++++++
 2 files changed

// File: rtl/seq_divider_if.sv
// Request/response bundle for seq_divider: operands and start in, status and results out.
interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder
  );
endinterface

// File: rtl/seq_divider.sv
// Restoring sequential divider, one quotient bit per cycle, with div-by-zero and overflow shortcuts.
// Define DIVIDER_SIGNED_EN to honour is_signed; otherwise every operation is unsigned.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  seq_divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] div_q;
  logic [CW-1:0]    count;
  logic             neg_quo;
  logic             neg_rem;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             sign_a;
  logic             sign_b;
  logic             is_zero;
  logic             is_ovf;

  // Operands are reduced to magnitudes so the core only ever divides unsigned values.
  always_comb begin
    sign_a = 1'b0;
    sign_b = 1'b0;
    is_ovf = 1'b0;
`ifdef DIVIDER_SIGNED_EN
    if (bus.is_signed) begin
      sign_a = bus.dividend[WIDTH-1];
      sign_b = bus.divisor[WIDTH-1];
    end
    is_ovf = bus.is_signed && (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (&bus.divisor);
`endif
    mag_a   = sign_a ? -bus.dividend : bus.dividend;
    mag_b   = sign_b ? -bus.divisor  : bus.divisor;
    is_zero = (bus.divisor == '0);
  end

`ifndef DIVIDER_SIGNED_EN
  logic unused_is_signed;
  assign unused_is_signed = bus.is_signed;
`endif

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;

  // The extra difference bit is the borrow: set means the trial subtraction went negative.
  always_comb begin
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    diff      = rem_shift - {1'b0, div_q};
    if (!diff[WIDTH]) begin
      step_rem = diff[WIDTH-1:0];
      step_quo = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      step_rem = rem_shift[WIDTH-1:0];
      step_quo = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_next = (is_zero || is_ovf) ? DONE : CALC;
      end
      CALC: begin
        bus.busy = 1'b1;
        if (count == CW'(1)) state_next = DONE;
      end
      DONE: begin
        bus.busy   = 1'b1;
        bus.done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Results land on the edge entering DONE and stay put until the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q         <= '0;
      quo_q         <= '0;
      div_q         <= '0;
      count         <= '0;
      neg_quo       <= 1'b0;
      neg_rem       <= 1'b0;
      bus.quotient  <= '0;
      bus.remainder <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            count   <= CW'(WIDTH);
            rem_q   <= '0;
            quo_q   <= mag_a;
            div_q   <= mag_b;
            neg_quo <= sign_a ^ sign_b;
            neg_rem <= sign_a;
            if (is_zero) begin
              bus.quotient  <= '1;
              bus.remainder <= bus.dividend;
            end else if (is_ovf) begin
              bus.quotient  <= bus.dividend;
              bus.remainder <= '0;
            end
          end
        end
        CALC: begin
          rem_q <= step_rem;
          quo_q <= step_quo;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            bus.quotient  <= neg_quo ? -step_quo : step_quo;
            bus.remainder <= neg_rem ? -step_rem : step_rem;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
